// File: rtl/frame_sequencer.sv
// Table-driven source of MicroBlaze-to-MIPS control frames with programmable idle gaps.
module frame_sequencer #(
  parameter int unsigned         NB_FRAME   = 32,
  parameter int unsigned         DEPTH      = 16,
  parameter int unsigned         NB_DELAY   = 16,
  parameter logic [NB_FRAME-1:0] IDLE_FRAME = 32'h2800_0000,
  localparam int unsigned        NB_ADDR    = $clog2(DEPTH)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_wr_en,
  input  logic [NB_ADDR-1:0]  i_wr_addr,
  input  logic [NB_FRAME-1:0] i_wr_frame,
  input  logic [NB_DELAY-1:0] i_wr_delay,
  input  logic [NB_ADDR:0]    i_len,
  input  logic                i_loop,
  input  logic                i_start,
  input  logic                i_abort,
  output logic [NB_FRAME-1:0] o_frame,
  output logic                o_frame_strobe,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_ADDR-1:0]  o_index
);

  localparam int unsigned NB_LEN   = NB_ADDR + 1;
  localparam int unsigned NB_ENTRY = NB_FRAME + NB_DELAY;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [NB_ENTRY-1:0] mem_q [DEPTH];

  logic [1:0]          state_r, state_n;
  logic [NB_ADDR-1:0]  idx_r, idx_n;
  logic [NB_DELAY-1:0] cnt_r, cnt_n;
  logic [NB_FRAME-1:0] wf_r, wf_n;
  logic [NB_LEN-1:0]   len_r, len_n;
  logic                loop_r, loop_n;
  logic [NB_FRAME-1:0] frame_n;
  logic                strobe_n, busy_n, done_n;

  logic [NB_ADDR-1:0]  rd_addr;
  logic [NB_ENTRY-1:0] rd_entry;
  logic [NB_FRAME-1:0] rd_frame;
  logic [NB_DELAY-1:0] rd_delay;
  logic                last_c;
  logic                load_c;

  // Command table: single write port, gated by the global enable.
  always_ff @(posedge i_clock) begin
    if (i_wr_en && i_valid) begin
      mem_q[i_wr_addr] <= {i_wr_frame, i_wr_delay};
    end
  end

  assign last_c   = (NB_LEN'(idx_r) == (len_r - NB_LEN'(1)));
  assign rd_entry = mem_q[rd_addr];
  assign rd_frame = rd_entry[NB_ENTRY-1:NB_DELAY];
  assign rd_delay = rd_entry[NB_DELAY-1:0];
  assign o_index  = idx_r;

  // Entry that becomes current at the next edge: 0 on start or wrap, else the successor.
  always_comb begin
    rd_addr = '0;
    if ((state_r == ST_EMIT) && !last_c) begin
      rd_addr = idx_r + NB_ADDR'(1);
    end
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_n  = state_r;
    idx_n    = idx_r;
    cnt_n    = cnt_r;
    wf_n     = wf_r;
    len_n    = len_r;
    loop_n   = loop_r;
    frame_n  = IDLE_FRAME;
    strobe_n = 1'b0;
    busy_n   = o_busy;
    done_n   = 1'b0;
    load_c   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            done_n = 1'b1;
          end else begin
            len_n  = (i_len > NB_LEN'(DEPTH)) ? NB_LEN'(DEPTH) : i_len;
            loop_n = i_loop;
            idx_n  = '0;
            busy_n = 1'b1;
            load_c = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_r == '0) begin
          state_n  = ST_EMIT;
          frame_n  = wf_r;
          strobe_n = 1'b1;
        end else begin
          cnt_n = cnt_r - NB_DELAY'(1);
        end
      end
      ST_EMIT: begin
        if (!last_c) begin
          idx_n  = idx_r + NB_ADDR'(1);
          load_c = 1'b1;
        end else if (loop_r) begin
          idx_n  = '0;
          load_c = 1'b1;
        end else begin
          state_n = ST_IDLE;
          idx_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        busy_n  = 1'b0;
      end
    endcase

    // A zero gap goes straight to emission, so the frame lands in the very next cycle.
    if (load_c) begin
      wf_n = rd_frame;
      if (rd_delay == '0) begin
        state_n  = ST_EMIT;
        frame_n  = rd_frame;
        strobe_n = 1'b1;
      end else begin
        state_n = ST_WAIT;
        cnt_n   = rd_delay - NB_DELAY'(1);
      end
    end

    if (i_abort) begin
      state_n  = ST_IDLE;
      idx_n    = '0;
      frame_n  = IDLE_FRAME;
      strobe_n = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
    end
  end

  // State and output registers; everything holds while i_valid is low.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r        <= ST_IDLE;
      idx_r          <= '0;
      cnt_r          <= '0;
      wf_r           <= IDLE_FRAME;
      len_r          <= '0;
      loop_r         <= 1'b0;
      o_frame        <= IDLE_FRAME;
      o_frame_strobe <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else if (i_valid) begin
      state_r        <= state_n;
      idx_r          <= idx_n;
      cnt_r          <= cnt_n;
      wf_r           <= wf_n;
      len_r          <= len_n;
      loop_r         <= loop_n;
      o_frame        <= frame_n;
      o_frame_strobe <= strobe_n;
      o_busy         <= busy_n;
      o_done         <= done_n;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer against a schedule-level reference model.
module tb_frame_sequencer;

  localparam int unsigned DEPTH      = 16;
  localparam logic [31:0] IDLE_FRAME = 32'h2800_0000;
  localparam logic [31:0] FR_A       = 32'h0A00_0000;
  localparam logic [31:0] FR_B       = 32'h2600_0000;
  localparam logic [31:0] FR_C       = 32'h0600_0000;
  localparam logic [31:0] FR_N       = 32'h0E33_1234;

  typedef struct packed {
    logic [31:0] frame;
    logic        strobe;
    logic        busy;
    logic        done;
    logic [3:0]  index;
  } obs_t;

  logic        tb_clock_i = 1'b0;
  logic        reset, valid, wr_en, loop, start, abort;
  logic [3:0]  wr_addr;
  logic [31:0] wr_frame;
  logic [15:0] wr_delay;
  logic [4:0]  len;
  logic [31:0] o_frame;
  logic        o_frame_strobe, o_busy, o_done;
  logic [3:0]  o_index;

  logic [31:0] mdl_frame [DEPTH];
  logic [15:0] mdl_delay [DEPTH];

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t got, e;

  localparam obs_t RESET_OBS = '{frame: IDLE_FRAME, strobe: 1'b0, busy: 1'b0, done: 1'b0, index: 4'd0};

  frame_sequencer dut (
    .i_clock        (tb_clock_i),
    .i_reset        (reset),
    .i_valid        (valid),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_frame     (wr_frame),
    .i_wr_delay     (wr_delay),
    .i_len          (len),
    .i_loop         (loop),
    .i_start        (start),
    .i_abort        (abort),
    .o_frame        (o_frame),
    .o_frame_strobe (o_frame_strobe),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_index        (o_index)
  );

  always #5 tb_clock_i = ~tb_clock_i;

  // Expected outputs in cycle c after a start accepted at edge 0: frame k lands
  // 1+delay[k] cycles after frame k-1 (or after the start edge).
  function automatic obs_t model_at(input int c, input int n, input bit lp, input int ab);
    obs_t r;
    int   l;
    int   t;
    r = RESET_OBS;
    l = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    if (ab > 0 && c > ab) return r;
    if (l == 0) begin
      r.done = (c == 1);
      return r;
    end
    t = 0;
    for (int k = 0; k < 200000; k++) begin
      if (!lp && k == l) begin
        r.done = (c == t + 1);
        return r;
      end
      t = t + 1 + int'(mdl_delay[k % l]);
      if (c <= t) begin
        r.busy  = 1'b1;
        r.index = 4'(k % l);
        if (c == t) begin
          r.strobe = 1'b1;
          r.frame  = mdl_frame[k % l];
        end
        return r;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge tb_clock_i);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [31:0] f, input logic [15:0] d);
    wr_en    = 1'b1;
    wr_addr  = 4'(a);
    wr_frame = f;
    wr_delay = d;
    tick();
    wr_en = 1'b0;
    mdl_frame[a] = f;
    mdl_delay[a] = d;
  endtask

  task automatic start_play(input int n, input bit lp);
    len   = 5'(n);
    loop  = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_plan_table();
    write_entry(0, FR_A, 16'd4);
    write_entry(1, FR_B, 16'd1);
    write_entry(2, FR_C, 16'd1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
    n_cmp++;
    if (got !== RESET_OBS) begin
      n_err++;
      $display("FAIL reset_values: got %h required %h", got, RESET_OBS);
    end
    reset = 1'b0;
    tick();
    got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
    n_cmp++;
    if (got !== RESET_OBS) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h required %h", got, RESET_OBS);
    end
  endtask

  task automatic test_single_pass();
    load_plan_table();
    start_play(3, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      e   = model_at(c, 3, 1'b0, 0);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL single_pass cycle %0d: got %h required %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_loop();
    load_plan_table();
    start_play(3, 1'b1);
    for (int c = 1; c <= 23; c++) begin
      e   = model_at(c, 3, 1'b1, 20);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL loop cycle %0d: got %h required %h", c, got, e);
      end
      abort = (c == 20);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int ab_at [2] = '{12, 9};
    bit ab_lp [2] = '{1'b1, 1'b0};
    load_plan_table();
    for (int r = 0; r < 2; r++) begin
      start_play(3, ab_lp[r]);
      for (int c = 1; c <= 16; c++) begin
        e   = model_at(c, 3, ab_lp[r], ab_at[r]);
        got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL abort run %0d cycle %0d: got %h required %h", r, c, got, e);
        end
        abort = (c == ab_at[r]);
        tick();
      end
      abort = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    write_entry(0, 32'h0E02_0001, 16'd0);
    write_entry(1, 32'h0E10_0001, 16'd0);
    start_play(2, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      e   = model_at(c, 2, 1'b0, 0);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got %h required %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_zero_len();
    start_play(0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      e   = model_at(c, 0, 1'b0, 0);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL zero_len cycle %0d: got %h required %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_len_overflow();
    int stop;
    int strobes;
    strobes = 0;
    for (int a = 0; a < int'(DEPTH); a++) write_entry(a, $urandom, 16'($urandom_range(0, 3)));
    start_play(DEPTH + 1, 1'b0);
    stop = 1000;
    for (int c = 1; c <= 1000; c++) begin
      e   = model_at(c, DEPTH + 1, 1'b0, 0);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      strobes += int'(o_frame_strobe);
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL len_overflow cycle %0d: got %h required %h", c, got, e);
      end
      if (e.done) stop = c + 1;
      tick();
      if (c == stop) break;
    end
    n_cmp++;
    if (strobes !== int'(DEPTH)) begin
      n_err++;
      $display("FAIL len_overflow_count: got %0d frames required %0d", strobes, DEPTH);
    end
  endtask

  task automatic test_random();
    int n;
    int stop;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int a = 0; a < n; a++) write_entry(a, $urandom, 16'($urandom_range(0, 5)));
      start_play(n, 1'b0);
      stop = 1000;
      for (int c = 1; c <= 1000; c++) begin
        e   = model_at(c, n, 1'b0, 0);
        got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL random it %0d cycle %0d: got %h required %h", it, c, got, e);
        end
        // Start/len/loop noise while busy must not disturb the latched playback.
        start = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
        len   = 5'($urandom_range(0, 31));
        loop  = 1'($urandom_range(0, 1));
        if (e.done) stop = c + 1;
        tick();
        if (c == stop) break;
      end
      start = 1'b0;
      loop  = 1'b0;
    end
  endtask

  task automatic test_max_delay();
    write_entry(0, 32'h1234_5678, 16'hFFFF);
    start_play(1, 1'b0);
    for (int c = 1; c <= 65538; c++) begin
      e   = model_at(c, 1, 1'b0, 0);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL max_delay cycle %0d: got %h required %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_overwrite_stall();
    int          st_cyc [4] = '{8, 10, 12, 17};
    logic [31:0] st_fr  [4] = '{FR_A, FR_B, FR_C, FR_N};
    obs_t        x;
    int          seen;
    load_plan_table();
    start_play(3, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      seen = 0;
      x    = RESET_OBS;
      x.busy = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (st_cyc[k] < c) seen++;
        if (st_cyc[k] == c) begin
          x.strobe = 1'b1;
          x.frame  = st_fr[k];
        end
      end
      x.index = 4'(seen % 3);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== x) begin
        n_err++;
        $display("FAIL overwrite_stall cycle %0d: got %h required %h", c, got, x);
      end
      wr_en    = (c == 2);
      wr_addr  = 4'd0;
      wr_frame = FR_N;
      wr_delay = 16'd4;
      valid    = !(c >= 3 && c <= 5);
      tick();
    end
    wr_en = 1'b0;
    valid = 1'b1;
    mdl_frame[0] = FR_N;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
    n_cmp++;
    if (got !== RESET_OBS) begin
      n_err++;
      $display("FAIL overwrite_stall_abort: got %h required %h", got, RESET_OBS);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    load_plan_table();
    start_play(3, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      e   = model_at(c, 3, 1'b0, 0);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_mid_wait pre cycle %0d: got %h required %h", c, got, e);
      end
      reset = (c == 3);
      tick();
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== RESET_OBS) begin
        n_err++;
        $display("FAIL reset_mid_wait post %0d: got %h required %h", c, got, RESET_OBS);
      end
      tick();
    end
    start_play(3, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      e   = model_at(c, 3, 1'b0, 0);
      got = {o_frame, o_frame_strobe, o_busy, o_done, o_index};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_mid_wait replay cycle %0d: got %h required %h", c, got, e);
      end
      tick();
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_frame = '0;
    wr_delay = '0;
    len      = '0;
    loop     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    test_reset();
    test_single_pass();
    test_loop();
    test_abort();
    test_back_to_back();
    test_zero_len();
    test_len_overflow();
    test_random();
    test_overwrite_stall();
    test_reset_mid_wait();
    test_max_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Programmable synthesizable generator of 32-bit MicroBlaze-to-MIPS control frames ({instruction_code[6], valid[1], addr_type[9], address[16]}).
- Drives the pipeline's i_frame_from_blaze in place of hard-coded per-cycle stimulus.
- Holds a table of {frame, delay} entries. Replays it once or in a loop, and emits each frame for exactly one cycle after a programmed gap of idle frames.
- Used on-board for bring-up and in simulation as a reusable command source.

Parameters:
- NB_FRAME, 32, width of one control frame.
- DEPTH, 16, number of table entries (power of two, >=2).
- NB_DELAY, 16, width of the per-entry idle-gap counter.
- IDLE_FRAME, 32'h2800_0000, frame driven when no command is issued (code 6'b0010_10, valid 0).
- NB_ADDR, clogb2(DEPTH-1), derived table index width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  global throughput enable. When low, all state, counters, outputs and table writes hold.
- i_wr_en  in  1  table write strobe.
- i_wr_addr  in  NB_ADDR  table write index.
- i_wr_frame  in  NB_FRAME  frame to store.
- i_wr_delay  in  NB_DELAY  idle cycles preceding this frame.
- i_len  in  NB_ADDR+1  number of entries to play, sampled on start.
- i_loop  in  1  replay continuously, sampled on start.
- i_start  in  1  begin playback (level sampled, acted on in IDLE only).
- i_abort  in  1  stop playback immediately.
- o_frame  out  NB_FRAME  current frame to pipeline.
- o_frame_strobe  out  1  high in the cycle a table frame is on o_frame.
- o_busy  out  1  playback in progress.
- o_done  out  1  one-cycle pulse at end of non-loop playback.
- o_index  out  NB_ADDR  index of the entry currently being waited on or emitted.

Behaviour:
- Reset:
  - o_frame=IDLE_FRAME; o_frame_strobe=0, o_busy=0, o_done=0, o_index=0.
  - State IDLE; loaded len/loop cleared.
  - Table contents are not cleared.
- All outputs are registered.
- Table:
  - DEPTH x (NB_FRAME+NB_DELAY), single write port, asynchronous read.
  - Write occurs at the edge when i_wr_en && i_valid, in any state.
- State machine: IDLE, WAIT, EMIT.
- IDLE:
  - i_start && i_len!=0: latch len=min(i_len,DEPTH) and loop; index=0; load working regs {frame,delay} from entry 0; o_busy=1; go WAIT.
  - i_start && i_len==0: o_done pulses next cycle; stay IDLE.
- Entry latch:
  - Working regs are loaded from the table when an entry becomes current.
  - Later writes to that entry do not affect the in-flight copy.
  - A write and a latch of the same address at the same edge latches the old content (read-before-write).
- WAIT:
  - o_frame=IDLE_FRAME, strobe=0.
  - If counter==0 go EMIT; else decrement.
  - Result: the frame appears exactly delay idle cycles after the previous frame cycle, or after the start edge.
- EMIT (one cycle): o_frame=working frame, o_frame_strobe=1. At the end of the cycle:
  - index<len-1: index+1, latch next entry, go WAIT.
  - index==len-1 && loop: index wraps to 0, latch entry 0, go WAIT. o_done is not pulsed.
  - index==len-1 && !loop: go IDLE, o_busy=0, o_done=1 for one cycle, o_index=0.
- Timing: start accepted at edge T gives frame[0] strobed in cycle T+1+delay[0].
  - delay=0 places frames back-to-back with no idle cycle between them.
- i_abort:
  - From any state, next edge gives IDLE, o_frame=IDLE_FRAME, strobe=0, busy=0, index=0, no o_done.
  - Priority: i_reset > i_abort > i_start. An abort in the same cycle as an EMIT suppresses the subsequent transition; the already-registered frame cycle is not retracted.
- i_start while busy is ignored; i_len, i_loop and table writes during playback do not change the latched len/loop.
- Counter is NB_DELAY bits unsigned. The maximum delay 2^NB_DELAY-1 must be honoured exactly, with no wrap.
- i_valid low for N cycles stretches every phase by N; no cycle or frame is lost or duplicated.

Test Plan:
- Program 0:{32'h0A00_0000,4}, 1:{32'h2600_0000,1}, 2:{32'h0600_0000,1}; len=3, loop=0, start at edge 0 -> strobes in cycles 5, 7, 9 with those frames; IDLE_FRAME otherwise; o_done in cycle 10; busy cycles 1-9.
- Same table, loop=1 -> sequence repeats (next 32'h0A00_0000 in cycle 14), o_index wraps 2->0, no o_done; abort at cycle 12 -> IDLE_FRAME from 13, busy=0, no done.
- Entry 0:{32'h0E02_0001,0}, entry 1:{32'h0E10_0001,0}, len=2 -> frames in cycles 1 and 2 back-to-back, done in cycle 3.
- i_len=0 with start -> no strobe, o_done one cycle, busy never high. i_len=DEPTH+1 -> exactly DEPTH frames.
- During playback, overwrite current entry with new frame, and hold i_valid low 3 cycles mid-WAIT -> old frame emitted, emission shifted by exactly 3 cycles; new frame used on next loop pass.
- Synchronous reset asserted mid-WAIT -> next cycle all outputs at reset values; table contents retained; replay after start matches original.
